// File: rtl/dec_queue_stage.sv
// Buffered MIPS32-subset decode stage: DEPTH-entry instruction FIFO feeding a registered
// decoded-output stage. Optional macro DEC_SPECIAL2_EN enables SPECIAL2 MUL/MADD(U)/MSUB(U).
module dec_queue_stage #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [PC_W-1:0]  out_pc,
  output logic [20:0]      out_ctrl,
  output logic [CNT_W-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic       is_eret;
    logic       is_break;
    logic       is_syscall;
    logic       is_invalid;
    logic       mflo;
    logic       mfhi;
    logic       cp0toreg;
    logic       hilotoreg;
    logic       memread;
    logic       regwrite;
    logic [1:0] regdst;
    logic       alusrc;
    logic       branch;
    logic       memwrite;
    logic       memtoreg;
    logic       jump;
    logic       hilo_write;
    logic       jbral;
    logic       jr;
    logic       cp0_write;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [31:0] inst);
    ctrl_t      c;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    op = inst[31:26];
    rs = inst[25:21];
    rt = inst[20:16];
    fn = inst[5:0];
    c  = '0;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: begin
            c.regwrite = 1'b1;
            c.regdst   = 2'b01;
          end
          6'h10: begin
            c.regwrite  = 1'b1;
            c.regdst    = 2'b01;
            c.hilotoreg = 1'b1;
            c.mfhi      = 1'b1;
          end
          6'h12: begin
            c.regwrite  = 1'b1;
            c.regdst    = 2'b01;
            c.hilotoreg = 1'b1;
            c.mflo      = 1'b1;
          end
          6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: c.hilo_write = 1'b1;
          6'h08: begin
            c.jump = 1'b1;
            c.jr   = 1'b1;
          end
          6'h09: begin
            c.regwrite = 1'b1;
            c.regdst   = 2'b01;
            c.jump     = 1'b1;
            c.jr       = 1'b1;
            c.jbral    = 1'b1;
          end
          6'h0C:   c.is_syscall = 1'b1;
          6'h0D:   c.is_break   = 1'b1;
          default: c.is_invalid = 1'b1;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h01: c.branch = 1'b1;
          5'h10, 5'h11: begin
            c.branch   = 1'b1;
            c.regwrite = 1'b1;
            c.regdst   = 2'b10;
            c.jbral    = 1'b1;
          end
          default: c.is_invalid = 1'b1;
        endcase
      end
      6'h02: c.jump = 1'b1;
      6'h03: begin
        c.jump     = 1'b1;
        c.regwrite = 1'b1;
        c.regdst   = 2'b10;
        c.jbral    = 1'b1;
      end
      6'h04, 6'h05, 6'h06, 6'h07: c.branch = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
      end
      6'h10: begin
        if (inst == 32'h4200_0018) c.is_eret = 1'b1;
        else if (rs == 5'h00) begin
          c.regwrite = 1'b1;
          c.cp0toreg = 1'b1;
        end
        else if (rs == 5'h04) c.cp0_write = 1'b1;
        else c.is_invalid = 1'b1;
      end
`ifdef DEC_SPECIAL2_EN
      6'h1C: begin
        case (fn)
          6'h02: begin
            c.regwrite = 1'b1;
            c.regdst   = 2'b01;
          end
          6'h00, 6'h01, 6'h04, 6'h05: c.hilo_write = 1'b1;
          default: c.is_invalid = 1'b1;
        endcase
      end
`endif
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.memtoreg = 1'b1;
        c.memread  = 1'b1;
      end
      6'h28, 6'h29, 6'h2B: begin
        c.alusrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      default: c.is_invalid = 1'b1;
    endcase
    return c;
  endfunction

  logic [31+PC_W:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q;
  logic [31:0]      out_inst_q;
  logic [PC_W-1:0]  out_pc_q;
  ctrl_t            out_ctrl_q;

  logic             push, pop, load, fifo_take, bypass, fifo_write;
  logic [31:0]      src_inst;
  logic [PC_W-1:0]  src_pc;

  assign in_ready = (cnt_q < CNT_W'(DEPTH)) & ~flush;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid_q & out_ready;
  assign load     = ~out_valid_q | pop;

  // Bypass only from an empty FIFO so older entries always leave first.
  assign fifo_take  = load & (cnt_q != '0);
  assign bypass     = load & (cnt_q == '0) & push;
  assign fifo_write = push & ~bypass;

  always_comb begin
    src_inst = in_inst;
    src_pc   = in_pc;
    if (fifo_take) {src_inst, src_pc} = mem_q[rd_q];
    wr_d  = fifo_write ? wr_q + PTR_W'(1) : wr_q;
    rd_d  = fifo_take  ? rd_q + PTR_W'(1) : rd_q;
    cnt_d = cnt_q + CNT_W'(fifo_write) - CNT_W'(fifo_take);
  end

  always_ff @(posedge clk) begin
    if (fifo_write) mem_q[wr_q] <= {in_inst, in_pc};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      out_ctrl_q  <= '0;
    end else if (flush) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (load) begin
        out_valid_q <= fifo_take | bypass;
        if (fifo_take | bypass) begin
          out_inst_q <= src_inst;
          out_pc_q   <= src_pc;
          out_ctrl_q <= decode(src_inst);
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;
  assign out_ctrl  = out_ctrl_q;
  assign occupancy = cnt_q;

endmodule

// File: tb/tb_dec_queue_stage.sv
// Directed + randomized bench for dec_queue_stage against a queue-based reference model.
module tb_dec_queue_stage;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [20:0] CP0W = 21'h000001, JRB = 21'h000002, JBRAL = 21'h000004;
  localparam logic [20:0] HLW  = 21'h000008, JMP = 21'h000010, M2R   = 21'h000020;
  localparam logic [20:0] MW   = 21'h000040, BR  = 21'h000080, ASRC  = 21'h000100;
  localparam logic [20:0] DRD  = 21'h000200, D31 = 21'h000400, RW    = 21'h000800;
  localparam logic [20:0] MR   = 21'h001000, H2R = 21'h002000, C2R   = 21'h004000;
  localparam logic [20:0] MFH  = 21'h008000, MFL = 21'h010000, INV   = 21'h020000;
  localparam logic [20:0] SYS  = 21'h040000, BRK = 21'h080000, ERT   = 21'h100000;

  logic             clk = 1'b0;
  logic             resetn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_inst, out_inst;
  logic [PC_W-1:0]  in_pc, out_pc;
  logic [20:0]      out_ctrl;
  logic [CNT_W-1:0] occupancy;

  dec_queue_stage #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_ctrl(out_ctrl), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } item_t;

  // Everything accepted and not yet consumed: head is the output register, rest is the FIFO.
  item_t items[$];

  int unsigned n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else n_fail++;
    assert (obs === exp) else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic int model_occ();
    return (items.size() > 0) ? items.size() - 1 : 0;
  endfunction

  function automatic logic [20:0] ref_ctrl(input logic [31:0] w);
    int op, fn, rs, rt;
    op = int'(w[31:26]);
    rs = int'(w[25:21]);
    rt = int'(w[20:16]);
    fn = int'(w[5:0]);
    if (op == 0) begin
      if (fn inside {0, 2, 3, 4, 6, 7, [32:39], 42, 43}) return RW | DRD;
      if (fn == 16) return RW | DRD | H2R | MFH;
      if (fn == 18) return RW | DRD | H2R | MFL;
      if (fn inside {17, 19, [24:27]}) return HLW;
      if (fn == 8) return JMP | JRB;
      if (fn == 9) return RW | DRD | JMP | JRB | JBRAL;
      if (fn == 12) return SYS;
      if (fn == 13) return BRK;
      return INV;
    end
    if (op == 1) begin
      if (rt inside {0, 1}) return BR;
      if (rt inside {16, 17}) return BR | RW | D31 | JBRAL;
      return INV;
    end
    if (op == 2) return JMP;
    if (op == 3) return JMP | RW | D31 | JBRAL;
    if (op inside {[4:7]}) return BR;
    if (op inside {[8:15]}) return RW | ASRC;
    if (op == 16) begin
      if (w == 32'h4200_0018) return ERT;
      if (rs == 0) return RW | C2R;
      if (rs == 4) return CP0W;
      return INV;
    end
`ifdef DEC_SPECIAL2_EN
    if (op == 28) begin
      if (fn == 2) return RW | DRD;
      if (fn inside {0, 1, 4, 5}) return HLW;
      return INV;
    end
`endif
    if (op inside {32, 33, 35, 36, 37}) return RW | ASRC | M2R | MR;
    if (op inside {40, 41, 43}) return ASRC | MW;
    return INV;
  endfunction

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(items.size() > 0));
    chk("occupancy", 64'(occupancy), 64'(model_occ()));
    if (items.size() > 0) begin
      chk("out_inst", 64'(out_inst), 64'(items[0].inst));
      chk("out_pc", 64'(out_pc), 64'(items[0].pc));
      chk("out_ctrl", 64'(out_ctrl), 64'(ref_ctrl(items[0].inst)));
    end
  endtask

  // One clock: entered and left just after a falling edge.
  task automatic cycle(input logic rn, input logic v, input logic [31:0] inst,
                       input logic [31:0] pc, input logic ord, input logic fl);
    logic exp_rdy;
    resetn = rn; in_valid = v; in_inst = inst; in_pc = pc; out_ready = ord; flush = fl;
    #1;
    exp_rdy = (model_occ() < DEPTH) && !fl;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (!rn || fl) items.delete();
    else begin
      if (items.size() > 0 && ord) void'(items.pop_front());
      if (v && exp_rdy) items.push_back('{inst, pc});
    end
    @(negedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic [31:0] pick(input int unsigned k);
    case (k)
      0:  return 32'h0022_1821;  1:  return 32'h2042_0005;  2:  return 32'h8C22_0004;
      3:  return 32'hAC22_0008;  4:  return 32'h1022_0003;  5:  return 32'h0411_0002;
      6:  return 32'h0400_0001;  7:  return 32'h0C00_0010;  8:  return 32'h0800_0010;
      9:  return 32'h03E0_0008;  10: return 32'h0040_F809;  11: return 32'h0000_1810;
      12: return 32'h0000_1812;  13: return 32'h0022_0018;  14: return 32'h0000_000C;
      15: return 32'h0000_000D;  16: return 32'h4082_6000;  17: return 32'h4002_6000;
      18: return 32'h4200_0018;  19: return 32'h7022_1802;  20: return 32'h7022_0000;
      21: return 32'hFC00_0000;  22: return 32'h0405_0000;  23: return 32'h4200_0019;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;

    // Reset from unknown state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_inst", 64'(out_inst), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    resetn = 1'b1;
    #1;
    chk("rst_ready", 64'(in_ready), 64'd1);

    // Single ADDU with bypass latency of one cycle
    cycle(1, 1, 32'h0022_1821, 32'hBFC0_0000, 1, 0);
    chk("addu_valid", 64'(out_valid), 64'd1);
    chk("addu_ctrl", 64'(out_ctrl), 64'h00A00);
    chk("addu_pc", 64'(out_pc), 64'hBFC0_0000);
    chk("addu_occ", 64'(occupancy), 64'd0);
    cycle(1, 0, 0, 0, 1, 0);

    // Fill under stall, overflow attempt, full with pop, then drain in order
    for (int i = 0; i < 6; i++)
      cycle(1, 1, 32'h0000_0021 | (32'(i) << 11), 32'h0000_1000 + 32'(4 * i), 0, 0);
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_head", 64'(out_inst), 64'h0000_0021);
    cycle(1, 1, 32'h0000_3821, 32'h0000_2000, 1, 0);
    chk("fullpop_occ", 64'(occupancy), 64'd3);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 1, 0);
    chk("drained", 64'(out_valid), 64'd0);

    // Individual decodes
    cycle(1, 1, 32'h8C22_0004, 32'h100, 1, 0);
    chk("lw_ctrl", 64'(out_ctrl), 64'h01920);
    cycle(1, 1, 32'h0000_000C, 32'h104, 1, 0);
    chk("syscall_ctrl", 64'(out_ctrl), 64'h40000);
    cycle(1, 1, 32'h4200_0018, 32'h108, 1, 0);
    chk("eret_ctrl", 64'(out_ctrl), 64'h100000);
    cycle(1, 1, 32'hFC00_0000, 32'h10C, 1, 0);
    chk("op3f_ctrl", 64'(out_ctrl), 64'h20000);
    cycle(1, 1, 32'h7022_1802, 32'h110, 1, 0);
`ifdef DEC_SPECIAL2_EN
    chk("mul_ctrl", 64'(out_ctrl), 64'h00A00);
`else
    chk("mul_ctrl", 64'(out_ctrl), 64'h20000);
`endif
    cycle(1, 0, 0, 0, 1, 0);

    // Flush with 3 queued entries and a simultaneous push
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'h2042_0000 + 32'(i), 32'h200 + 32'(4 * i), 0, 0);
    chk("preflush_occ", 64'(occupancy), 64'd3);
    cycle(1, 1, 32'hDEAD_0021, 32'h300, 0, 1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 1, 0);
      chk("flush_gone", 64'(out_valid), 64'd0);
    end

    // Reset in the middle of a stall
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'h8C22_0000 + 32'(i), 32'h400 + 32'(4 * i), 0, 0);
    chk("prerst_occ", 64'(occupancy), 64'd2);
    cycle(0, 0, 0, 0, 0, 0);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_inst", 64'(out_inst), 64'd0);
    chk("mrst_pc", 64'(out_pc), 64'd0);
    chk("mrst_ctrl", 64'(out_ctrl), 64'd0);
    chk("mrst_occ", 64'(occupancy), 64'd0);
    resetn = 1'b1;
    #1;
    chk("mrst_ready", 64'(in_ready), 64'd1);

    // Randomized traffic against the reference queue
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 97) != 0, ($urandom % 4) != 0, pick($urandom % 28), $urandom,
            ($urandom % 3) != 0, ($urandom % 40) == 0);
    end
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
